// File: rtl/busca_ifid_pkg.sv
// Shared definitions for the fetch stage and IF/ID pipeline register.
package busca_ifid_pkg;

  typedef enum logic [1:0] {
    INICIO   = 2'd0,
    EXEC     = 2'd1,
    BOLHA    = 2'd2,
    DESCARTE = 2'd3
  } estado_t;

  localparam logic [31:0] NOP      = 32'h0000_0000;
  localparam logic [31:0] PC_RESET = 32'h0000_0000;
  localparam logic [31:0] PC_INC   = 32'd4;
  localparam int          CTRL_W   = 10;

endpackage

// File: rtl/busca_ifid_contador_sat.sv
// 16-bit event counter that sticks at all-ones instead of wrapping.
module contador_sat (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  output logic [15:0] count
);

  // Count enabled events, holding once the maximum value is reached
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= 16'h0000;
    end else if (en && (count != 16'hFFFF)) begin
      count <= count + 16'd1;
    end
  end

endmodule

// File: rtl/busca_ifid.sv
// Instruction fetch stage: PC, IF/ID register, hazard-driven control bubble,
// pipeline status FSM and stall/flush statistics.
module busca_ifid
  import busca_ifid_pkg::*;
(
  input  logic              Clock,
  input  logic              Resetn,
  input  logic              PCEscreve,
  input  logic              IFIDEscreve,
  input  logic              HazMuxControle,
  input  logic              branch_taken,
  input  logic [31:0]       branch_target,
  input  logic [31:0]       imem_instr,
  input  logic [CTRL_W-1:0] ctrl_in,
  output logic [31:0]       imem_addr,
  output logic [31:0]       IFID_instr,
  output logic [31:0]       IFID_pc4,
  output logic              IFID_valid,
  output logic [CTRL_W-1:0] ctrl_out,
  output logic [1:0]        estado,
  output logic              haz_err,
  output logic [15:0]       stall_count,
  output logic [15:0]       flush_count
);

  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        haz_inconsistente;
  estado_t     estado_q;
  estado_t     estado_next;

  assign pc_plus4          = pc + PC_INC;
  assign haz_inconsistente = PCEscreve && !IFIDEscreve;
  assign imem_addr         = pc;
  assign estado            = estado_q;

  // PC: a taken branch redirects, otherwise advance only when both stages may move
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      pc <= PC_RESET;
    end else if (branch_taken) begin
      pc <= branch_target;
    end else if (PCEscreve && IFIDEscreve) begin
      pc <= pc_plus4;
    end
  end

  // IF/ID register: flush on a taken branch, load when enabled, else hold
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      IFID_instr <= NOP;
      IFID_pc4   <= 32'h0000_0000;
      IFID_valid <= 1'b0;
    end else if (branch_taken) begin
      IFID_instr <= NOP;
      IFID_pc4   <= 32'h0000_0000;
      IFID_valid <= 1'b0;
    end else if (IFIDEscreve) begin
      IFID_instr <= imem_instr;
      IFID_pc4   <= pc_plus4;
      IFID_valid <= 1'b1;
    end
  end

  // Sticky flag for a PC write requested while IF/ID is frozen
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      haz_err <= 1'b0;
    end else if (haz_inconsistente && !branch_taken) begin
      haz_err <= 1'b1;
    end
  end

  // Next pipeline status: branch flush beats stall, stall beats normal run
  always_comb begin
    estado_next = EXEC;
    if (branch_taken) begin
      estado_next = DESCARTE;
    end else if (!PCEscreve || HazMuxControle) begin
      estado_next = BOLHA;
    end
  end

  // Status register; every destination differs from INICIO, so it is left on the first edge
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      estado_q <= INICIO;
    end else begin
      estado_q <= estado_next;
    end
  end

  // Bubble the ID/EX control word on hazards or when IF/ID holds no instruction
  always_comb begin
    ctrl_out = ctrl_in;
    if (HazMuxControle || !IFID_valid) begin
      ctrl_out = '0;
    end
  end

  contador_sat u_stall_cnt (
    .clk   (Clock),
    .rst_n (Resetn),
    .en    (estado_next == BOLHA),
    .count (stall_count)
  );

  contador_sat u_flush_cnt (
    .clk   (Clock),
    .rst_n (Resetn),
    .en    (estado_next == DESCARTE),
    .count (flush_count)
  );

endmodule

// File: doc/busca_ifid.md
BUSCA_IFID -- requirements
Module: busca_ifid

Interface
REQ-001 The module SHALL expose `Clock` (input, 1 bit), the single clock; all state updates on its rising edge.
REQ-002 The module SHALL expose `Resetn` (input, 1 bit); reset is asynchronous and active-low.
REQ-003 The module SHALL expose `PCEscreve` (input, 1 bit): PC write enable from the hazard unit.
REQ-004 The module SHALL expose `IFIDEscreve` (input, 1 bit): IF/ID register write enable from the hazard unit.
REQ-005 The module SHALL expose `HazMuxControle` (input, 1 bit): when 1, a bubble is inserted into ID/EX control.
REQ-006 The module SHALL expose `branch_taken` (input, 1 bit): branch resolved as taken.
REQ-007 The module SHALL expose `branch_target` (input, 32 bits): the branch destination.
REQ-008 The module SHALL expose `imem_instr` (input, 32 bits): instruction memory data for `imem_addr`, valid in the same cycle.
REQ-009 The module SHALL expose `ctrl_in` (input, 10 bits): decoder control word.
REQ-010 The module SHALL expose `imem_addr` (output, 32 bits): the current PC.
REQ-011 The module SHALL expose `IFID_instr`, `IFID_pc4` (outputs, 32 bits each) and `IFID_valid` (output, 1 bit): the IF/ID register contents.
REQ-012 The module SHALL expose `ctrl_out` (output, 10 bits): control word to ID/EX.
REQ-013 The module SHALL expose `estado` (output, 2 bits): FSM state.
REQ-014 The module SHALL expose `haz_err` (output, 1 bit): sticky error flag.
REQ-015 The module SHALL expose `stall_count` and `flush_count` (outputs, 16 bits each).

Function
REQ-016 PC update priority: `branch_taken` -> PC <= `branch_target`; else `PCEscreve`=1 and `IFIDEscreve`=1 -> PC <= PC+4 (mod 2^32, wraps 0xFFFFFFFC -> 0); else PC holds.
REQ-017 IF/ID update: `branch_taken` -> instr <= 0x00000000, pc4 <= 0, valid <= 0 (flush); else `IFIDEscreve`=1 -> instr <= `imem_instr`, pc4 <= PC+4, valid <= 1; else all three hold.
REQ-018 `ctrl_out` SHALL be combinational: 0 when `HazMuxControle`=1 or `IFID_valid`=0, else `ctrl_in`.
REQ-019 `PCEscreve`=1 with `IFIDEscreve`=0 (an inconsistent hazard) SHALL hold both PC and IF/ID, and set `haz_err`, which stays 1 until reset.
REQ-020 `PCEscreve`=0 with `IFIDEscreve`=1 SHALL load IF/ID and hold the PC, with no error.
REQ-021 FSM states: INICIO=0, EXEC=1, BOLHA=2, DESCARTE=3.
REQ-022 FSM transitions, evaluated every cycle with priority branch > stall > run:
- from any state: `branch_taken` -> DESCARTE;
- else `PCEscreve`=0 or `HazMuxControle`=1 -> BOLHA;
- else -> EXEC.
REQ-023 INICIO SHALL be left after exactly one clock edge following reset release.
REQ-024 `stall_count` SHALL increment on each edge where the next state is BOLHA; `flush_count` SHALL increment on each edge where the next state is DESCARTE; both saturate at 0xFFFF.
REQ-025 `branch_taken` coinciding with `PCEscreve`=0 SHALL follow the branch (the flush wins); only `flush_count` increments.

Reset
REQ-026 While `Resetn`=0, regardless of `Clock`, the module SHALL hold:
- PC = 0x00000000;
- `IFID_instr` = 0, `IFID_pc4` = 0, `IFID_valid` = 0;
- `estado` = INICIO;
- `haz_err` = 0;
- both counters = 0;
- `ctrl_out` = 0.
REQ-027 Reset asserted mid-stall or mid-flush SHALL discard all in-flight state; the first fetch after release is from address 0.

Structure
REQ-028 A shared package SHALL hold the FSM state encodings, the NOP constant 0x00000000, `PC_RESET` = 0x00000000, the PC increment constant 4, and the control width 10.
REQ-029 Exactly one sub-module, `contador_sat` (a 16-bit saturating counter with enable and async active-low reset), SHALL be instantiated twice.

Verification
REQ-030 Reset release with `PCEscreve`=`IFIDEscreve`=1, `imem_instr`=0x8C010004 -> after 1 edge: PC=4, `IFID_instr`=0x8C010004, `IFID_pc4`=4, `IFID_valid`=1, `estado`=EXEC.
REQ-031 Load-use stall: `PCEscreve`=0, `IFIDEscreve`=0, `HazMuxControle`=1 for 2 cycles at PC=8 -> PC stays 8, IF/ID holds, `ctrl_out`=0, `estado`=BOLHA, `stall_count`=2.
REQ-032 `branch_taken`=1, `branch_target`=0x40, with `PCEscreve`=0 -> next edge: PC=0x40, `IFID_valid`=0, `IFID_instr`=0, `estado`=DESCARTE, `flush_count`=1, `stall_count` unchanged.
REQ-033 `PCEscreve`=1 with `IFIDEscreve`=0 -> PC and IF/ID hold, `haz_err`=1; `haz_err` stays 1 after 5 further normal cycles.
REQ-034 Force PC=0xFFFFFFFC with normal advance -> next PC=0x00000000 and `IFID_pc4`=0.
REQ-035 Hold a stall for 70000 cycles -> `stall_count`=0xFFFF; then assert `Resetn`=0 mid-cycle -> all outputs reset immediately, without waiting for a clock edge.
